gpio_event_capture: RTL and testbench

// Input front end for the team_01 user project. Takes the raw bidirectional-pad

---
 rtl/gpio_event_capture.sv | 156 +++++++++++++++
 tb/tb_gpio_event_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_event_capture.sv
// Pad input front end: synchronise, debounce and timestamp each pin edge,
// then queue the events in a show-ahead FIFO behind a valid/ready port.
module gpio_event_capture #(
  parameter int NUM_IN          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TS_WIDTH        = 16,
  parameter int FIFO_DEPTH      = 8,
  localparam int IW = $clog2(NUM_IN),
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int DW = TS_WIDTH + IW + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en_i,
  input  logic [NUM_IN-1:0] pins_i,
  output logic [NUM_IN-1:0] pins_stable_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [DW-1:0]     evt_data_o,
  output logic [AW:0]       evt_count_o,
  output logic              overflow_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_IN-1:0]   s1_q, s2_q;
  logic [NUM_IN-1:0]   stable_q, stable_d;
  logic [CW-1:0]       cnt_q [NUM_IN];
  logic [CW-1:0]       cnt_d [NUM_IN];
  logic [NUM_IN-1:0]   chg;
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] cap_ts_q [NUM_IN];
  logic [NUM_IN-1:0]   edge_q;
  logic [NUM_IN-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;

  logic [DW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         count_q;

  logic                found;
  logic [IW-1:0]       push_idx;
  logic [NUM_IN-1:0]   grant;
  logic                push, pop;
  logic [DW-1:0]       push_data;

  // Per-pin debounce: count cycles of disagreement, accept after a full run
  always_comb begin
    stable_d = stable_q;
    chg      = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!en_i) begin
        cnt_d[i] = '0;
      end else if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CMAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        chg[i]      = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Lowest-index pending pin wins the single push slot
  always_comb begin
    found    = 1'b0;
    push_idx = '0;
    grant    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pend_q[i] && !found) begin
        found    = 1'b1;
        push_idx = IW'(i);
        grant[i] = 1'b1;
      end
    end
    pop       = evt_valid_o && evt_ready_i;
    push      = en_i && found && (count_q != FULL || pop);
    push_data = {cap_ts_q[push_idx], push_idx, edge_q[push_idx]};
    if (!push) grant = '0;
  end

  // Pending flags; a re-capture over an unpushed event is a lost edge
  always_comb begin
    pend_d = (pend_q & ~grant) | chg;
    ovf_d  = ovf_q | (|(chg & pend_q & ~grant));
    if (!en_i) pend_d = '0;
  end

  // Synchroniser, debounce state, timestamp and per-pin capture registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      ts_q     <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i]    <= '0;
        cap_ts_q[i] <= '0;
      end
    end else begin
      s1_q     <= pins_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      ts_q     <= ts_q + TS_WIDTH'(1);
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (chg[i]) begin
          cap_ts_q[i] <= ts_q;
          edge_q[i]   <= s2_q[i];
        end
      end
    end
  end

  // Event FIFO; disabling capture flushes it
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (!en_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pins_stable_o = stable_q;
  assign evt_valid_o   = (count_q != '0);
  assign evt_data_o    = evt_valid_o ? mem_q[rptr_q] : '0;
  assign evt_count_o   = count_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_gpio_event_capture.sv
// Directed bench for gpio_event_capture: debounce latency, glitch reject,
// arbitration, FIFO saturation/overflow, async reset and timestamp wrap.
module tb_gpio_event_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  pins;
  logic [3:0]  stable;
  logic        valid;
  logic        ready;
  logic [18:0] data;
  logic [3:0]  count;
  logic        ovf;

  logic [15:0] tb_ts;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_event_capture dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .en_i          (en),
    .pins_i        (pins),
    .pins_stable_o (stable),
    .evt_valid_o   (valid),
    .evt_ready_i   (ready),
    .evt_data_o    (data),
    .evt_count_o   (count),
    .overflow_o    (ovf)
  );

  // Reference free-running timestamp
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 16'd1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    n_tests += 5;
    if (stable !== 4'b0) begin n_fail++; $display("FAIL rst_stable got %h exp 0", stable); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", valid); end
    if (count !== 4'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    if (data !== 19'd0) begin n_fail++; $display("FAIL rst_data got %h exp 0", data); end
  endtask

  task automatic test_single_rise;
    logic [15:0] t;
    logic [18:0] e;
    pins = 4'b0001;
    t = tb_ts;
    e = {t + 16'd17, 2'd0, 1'b1};
    cyc(17);
    n_tests++;
    if (stable !== 4'b0000) begin n_fail++; $display("FAIL early_stable got %b exp 0000", stable); end
    cyc(1);
    n_tests += 2;
    if (stable !== 4'b0001) begin n_fail++; $display("FAIL stable_k17 got %b exp 0001", stable); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL early_valid got %b exp 0", valid); end
    cyc(1);
    n_tests += 3;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL valid_k18 got %b exp 1", valid); end
    if (data !== e) begin n_fail++; $display("FAIL rise_data got %h exp %h", data, e); end
    if (count !== 4'd1) begin n_fail++; $display("FAIL rise_count got %0d exp 1", count); end
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    n_tests++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL pop_count got %0d exp 0", count); end
  endtask

  task automatic test_glitch;
    pins = 4'b0101;
    cyc(10);
    pins = 4'b0001;
    cyc(30);
    n_tests += 2;
    if (stable !== 4'b0001) begin n_fail++; $display("FAIL glitch_stable got %b exp 0001", stable); end
    if (count !== 4'd0) begin n_fail++; $display("FAIL glitch_count got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] t;
    logic [18:0] e;
    ready = 1'b1;
    pins = 4'b0000;
    cyc(25);
    n_tests += 2;
    if (stable !== 4'b0000) begin n_fail++; $display("FAIL clr_stable got %b exp 0000", stable); end
    if (count !== 4'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", count); end
    pins = 4'b1111;
    t = tb_ts;
    cyc(18);
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early got %b exp 0", valid); end
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      e = {t + 16'd17, 2'(i), 1'b1};
      n_tests++;
      if (valid !== 1'b1 || data !== e) begin
        n_fail++;
        $display("FAIL b2b_evt%0d got v=%b %h exp v=1 %h", i, valid, data, e);
      end
    end
    cyc(1);
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [18:0] exp_q [10];
    logic [18:0] e;
    ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      pins[1] = ~pins[1];
      exp_q[j] = {tb_ts + 16'd17, 2'd1, pins[1]};
      cyc(20);
      if (j == 7) begin
        n_tests += 2;
        if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_fill got %0d exp 8", count); end
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", ovf); end
      end
      if (j == 8) begin
        n_tests += 2;
        if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_stall got %0d exp 8", count); end
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pend got %b exp 0", ovf); end
      end
    end
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", ovf); end
    ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      e = (k < 8) ? exp_q[k] : exp_q[9];
      n_tests++;
      if (valid !== 1'b1 || data !== e) begin
        n_fail++;
        $display("FAIL drain%0d got v=%b %h exp v=1 %h", k, valid, data, e);
      end
      cyc(1);
    end
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL drain_end got %b exp 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int j = 0; j < 3; j++) begin
      pins[3] = ~pins[3];
      cyc(20);
    end
    n_tests++;
    if (count !== 4'd3) begin n_fail++; $display("FAIL mid_fill got %0d exp 3", count); end
    rst = 1'b1;
    pins = 4'b0000;
    #1;
    n_tests += 4;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", valid); end
    if (count !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", count); end
    if (stable !== 4'b0) begin n_fail++; $display("FAIL mid_stable got %b exp 0", stable); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b exp 0", ovf); end
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic wait_ts(input logic [15:0] t);
    int g = 0;
    while (tb_ts !== t && g < 70000) begin
      @(negedge clk);
      g++;
    end
    if (tb_ts !== t) begin
      n_tests++;
      n_fail++;
      $display("FAIL ts_wait got %h exp %h", tb_ts, t);
    end
  endtask

  task automatic test_ts_wrap;
    logic [18:0] e;
    wait_ts(16'hFFED);
    pins = 4'b0001;
    wait_ts(16'hFFF2);
    pins = 4'b0011;
    wait_ts(16'h0010);
    e = {16'hFFFE, 2'd0, 1'b1};
    n_tests += 2;
    if (count !== 4'd2) begin n_fail++; $display("FAIL wrap_count got %0d exp 2", count); end
    if (data !== e) begin n_fail++; $display("FAIL wrap_ts0 got %h exp %h", data, e); end
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    e = {16'h0003, 2'd1, 1'b1};
    n_tests += 2;
    if (data !== e) begin n_fail++; $display("FAIL wrap_ts1 got %h exp %h", data, e); end
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %b exp 0", ovf); end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    pins  = 4'b0;
    ready = 1'b0;
    cyc(3);
    test_reset;
    rst = 1'b0;
    cyc(2);
    test_single_rise;
    test_glitch;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_ts_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
